// File: rtl/mult_share_pkg.sv
// Shared constants and types for the multiplier-sharing controller.
//   WIDTH_DEF   : default operand width (product is 2*WIDTH)
//   NREQ_DEF    : default number of requesters
//   NREQ_MAX    : largest supported requester count
//   LATENCY_DEF : default multiplier latency in clock edges
//   IDXW        : requester index width carried in the tag pipeline
//   tag_t       : one tag pipeline stage {valid, idx}
package mult_share_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int NREQ_DEF    = 4;
  localparam int NREQ_MAX    = 8;
  localparam int LATENCY_DEF = 3;

  // Sized for the largest legal NREQ so one tag type serves every build.
  localparam int IDXW = $clog2(NREQ_MAX);

  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
  } tag_t;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Client-side bus of the multiplier-sharing controller.
//   req_valid/req_ready : per-requester operand handshake
//   req_a/req_b         : operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : per-requester result handshake
//   rsp_y               : products, requester i at [i*2*WIDTH +: 2*WIDTH]
// master = client engines, slave = controller.
interface mult_share_ctrl_if
  import mult_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic [NREQ*2*WIDTH-1:0] rsp_y;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y
  );

endinterface

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesting lines, search starting
// at an internal pointer that moves to just past the winner on each grant.
//   clk, rst_n  : clock, asynchronous active-low reset (pointer -> 0)
//   req_i       : request vector
//   grant_o     : one-hot grant, 0 when nothing requests (combinational)
//   grant_idx_o : index of the granted line
//   grant_any_o : a grant is being issued this cycle
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int N = NREQ_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic            grant_any_o
);

  logic [IDXW-1:0] ptr_q, ptr_d;
  int              cand;

  // Walk from the farthest candidate back to the pointer; the last hit
  // written is therefore the nearest requester at or after ptr_q.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    cand        = 0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = (int'(ptr_q) + off) % N;
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        grant_idx_o   = IDXW'(cand);
        grant_any_o   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any_o) begin
      ptr_d = (grant_idx_o == IDXW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one pipelined multiplier between NREQ requesters. A round-robin
// arbiter issues at most one operation per cycle; a tag pipeline matched to
// the multiplier latency steers each product back to its issuer, where it is
// held until the requester accepts it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : client-side request/response bus (slave side)
//   mul_a_o    : operand a to the external multiplier
//   mul_b_o    : operand b to the external multiplier
//   mul_y_i    : product from the external multiplier
//   busy_o     : some requester has an operation outstanding
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_share_ctrl_if.slave   bus,
  output logic [WIDTH-1:0]   mul_a_o,
  output logic [WIDTH-1:0]   mul_b_o,
  input  logic [2*WIDTH-1:0] mul_y_i,
  output logic               busy_o
);

  localparam int YW = 2 * WIDTH;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] cap_vec;
  logic [NREQ-1:0] done_vec;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [IDXW-1:0] grant_idx;
  logic            grant_any;
  tag_t            tag_q [LATENCY];
  tag_t            tag_last;
  logic [YW-1:0]   result_q [NREQ];

  // Gating with rst_n keeps req_ready and the operand mux at 0 during reset
  // even if clients hold req_valid.
  assign eligible = bus.req_valid & ~pending_q & {NREQ{rst_n}};

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (eligible),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  assign bus.req_ready = grant;

  always_comb begin
    mul_a_o = '0;
    mul_b_o = '0;
    if (grant_any) begin
      mul_a_o = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
      mul_b_o = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
    end
  end

  assign tag_last = tag_q[LATENCY-1];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign cap_vec[gi]  = tag_last.valid && (tag_last.idx == IDXW'(gi));
      assign done_vec[gi] = rsp_valid_q[gi] & bus.rsp_ready[gi];
      assign bus.rsp_y[gi*YW +: YW] = result_q[gi];
    end
  endgenerate

  // One outstanding op per requester: a grant needs pending=0 and a capture
  // or response needs pending=1, so set and clear never collide on one bit.
  assign pending_d   = (pending_q | grant) & ~done_vec;
  assign rsp_valid_d = (rsp_valid_q | cap_vec) & ~done_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      rsp_valid_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k] <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        result_q[i] <= '0;
      end
    end else begin
      pending_q      <= pending_d;
      rsp_valid_q    <= rsp_valid_d;
      tag_q[0].valid <= grant_any;
      tag_q[0].idx   <= grant_idx;
      for (int k = 1; k < LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (cap_vec[i]) begin
          result_q[i] <= mul_y_i;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign busy_o        = |pending_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
module tb_mult_share_ctrl;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int L  = 3;
  localparam int YW = 2 * W;
  localparam int BOUND = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_share_ctrl_if #(.WIDTH(W), .NREQ(N)) bus ();

  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [YW-1:0] mul_y;
  logic          busy;

  mult_share_ctrl #(.WIDTH(W), .NREQ(N), .LATENCY(L)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .mul_a_o (mul_a),
    .mul_b_o (mul_b),
    .mul_y_i (mul_y),
    .busy_o  (busy)
  );

  // Input-registered multiplier model, L edges from operands to product.
  logic [YW-1:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= {8'b0, mul_a} * {8'b0, mul_b};
    for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_y = mpipe[L-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [YW-1:0] exp_q [N][$];
  int            grant_cyc [N];
  bit            outstanding [N];
  bit            seen [N];
  int            gcnt [N];
  logic [N-1:0]  prev_hold;
  logic [YW-1:0] prev_y [N];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: push on operand handshake, pop/compare on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_ready != '0) check("grant_onehot", $countones(bus.req_ready), 1);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i]) begin
          check("grant_has_valid", bus.req_valid[i], 1);
          check("grant_not_pending", outstanding[i], 0);
          check("mul_a_mux", mul_a, bus.req_a[i*W +: W]);
          check("mul_b_mux", mul_b, bus.req_b[i*W +: W]);
          exp_q[i].push_back({8'b0, bus.req_a[i*W +: W]} * {8'b0, bus.req_b[i*W +: W]});
          grant_cyc[i]   = cyc;
          outstanding[i] = 1'b1;
          gcnt[i]++;
        end
        if (prev_hold[i]) begin
          check("hold_valid", bus.rsp_valid[i], 1);
          check("hold_y", bus.rsp_y[i*YW +: YW], prev_y[i]);
        end
        if (bus.rsp_valid[i] && !seen[i]) begin
          seen[i] = 1'b1;
          check("rsp_expected", outstanding[i], 1);
          if (outstanding[i]) check("rsp_latency", cyc - grant_cyc[i], L + 1);
        end
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          if (exp_q[i].size() > 0) begin
            logic [YW-1:0] e;
            e = exp_q[i].pop_front();
            check("rsp_y", bus.rsp_y[i*YW +: YW], e);
            $display("txn req%0d y=%0d expected=%0d cycle=%0d", i, bus.rsp_y[i*YW +: YW], e, cyc);
          end
          outstanding[i] = 1'b0;
          seen[i]        = 1'b0;
        end
        prev_hold[i] = bus.rsp_valid[i] && !bus.rsp_ready[i];
        prev_y[i]    = bus.rsp_y[i*YW +: YW];
      end
    end else begin
      prev_hold = '0;
    end
  end

  task automatic clear_sb();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      outstanding[i] = 1'b0;
      seen[i]        = 1'b0;
    end
  endtask

  task automatic drive_op(input int i, input int a, input int b);
    bus.req_a[i*W +: W] = W'(a);
    bus.req_b[i*W +: W] = W'(b);
    bus.req_valid[i]    = 1'b1;
  endtask

  // Called just after a posedge; returns just after the posedge ending the grant cycle.
  task automatic send(input int i, input int a, input int b);
    int n = 0;
    drive_op(i, a, b);
    @(negedge clk);
    while (!bus.req_ready[i] && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("grant_in_time", (n < BOUND), 1);
    @(posedge clk);
    #1 bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_time", (n < BOUND), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_y"}, bus.rsp_y, 0);
    check({tag, "_mul_a"}, mul_a, 0);
    check({tag, "_mul_b"}, mul_b, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    int req;
    int a;
    int b;
    int y;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    int c1;
    int d0;
    int d1;

    vecs[0] = '{0, 13, 11, 143};
    vecs[1] = '{2, 255, 255, 65025};
    vecs[2] = '{2, 0, 200, 0};
    vecs[3] = '{2, 1, 255, 255};
    vecs[4] = '{3, 7, 9, 63};

    clear_sb();
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    prev_hold     = '0;
    bus.req_valid = '1;
    bus.req_a     = '1;
    bus.req_b     = '1;
    bus.rsp_ready = '1;

    // Outputs stay 0 under reset even with every request asserted.
    #12 check_outputs_zero("reset");
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: single op and extremes, one at a time.
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].req, vecs[v].a, vecs[v].b);
      @(negedge clk);
      check("busy_after_grant", busy, 1);
      n = 0;
      while (!bus.rsp_valid[vecs[v].req] && n < BOUND) begin
        @(negedge clk);
        n++;
      end
      check("vec_rsp_in_time", (n < BOUND), 1);
      check("vec_y", bus.rsp_y[vecs[v].req*YW +: YW], vecs[v].y);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("busy_cleared", busy, 0);
      @(posedge clk);
      #1;
    end

    // Contention: all four at once, pointer is back at 0.
    for (int i = 0; i < N; i++) drive_op(i, i + 1, 10);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("contention_grant", bus.req_ready, (1 << k));
      @(posedge clk);
      #1 bus.req_valid[k] = 1'b0;
    end
    wait_idle();

    // Fairness: 0 and 1 permanently valid.
    c0 = gcnt[0];
    c1 = gcnt[1];
    drive_op(0, 2, 3);
    drive_op(1, 5, 3);
    repeat (40) @(posedge clk);
    #1 bus.req_valid[1:0] = 2'b00;
    wait_idle();
    d0 = gcnt[0] - c0;
    d1 = gcnt[1] - c1;
    check("fair_balance", ((d0 - d1) <= 1 && (d1 - d0) <= 1), 1);
    check("fair_progress", (d0 >= 6 && d1 >= 6), 1);

    // Backpressure on requester 1 while requester 0 keeps being served.
    bus.rsp_ready[1] = 1'b0;
    send(1, 7, 9);
    drive_op(1, 2, 2);
    drive_op(0, 4, 4);
    c0 = gcnt[0];
    for (int j = 0; j < 22; j++) begin
      @(negedge clk);
      check("bp_no_regrant", bus.req_ready[1], 0);
      if (j >= 3) begin
        check("bp_rsp_valid", bus.rsp_valid[1], 1);
        check("bp_rsp_y", bus.rsp_y[1*YW +: YW], 63);
      end
    end
    check("bp_others_served", (gcnt[0] - c0 >= 3), 1);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 bus.rsp_ready[1] = 1'b1;
    @(negedge clk);
    check("bp_blocked_at_handshake", bus.req_ready[1], 0);
    @(negedge clk);
    check("bp_resume", bus.req_ready[1], 1);
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    wait_idle();

    // Reset mid-flight: pointer is at 2, so 0 then 1 get granted.
    drive_op(0, 3, 4);
    drive_op(1, 6, 6);
    @(negedge clk);
    check("mf_grant0", bus.req_ready, 4'b0001);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("mf_grant1", bus.req_ready, 4'b0010);
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    clear_sb();
    drive_op(2, 1, 1);
    #1 check_outputs_zero("midreset");
    @(posedge clk);
    #1 check_outputs_zero("midreset_hold");
    bus.req_valid[2] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("flush_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    send(3, 3, 5);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid[3] && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("post_reset_rsp_in_time", (n < BOUND), 1);
    check("post_reset_y", bus.rsp_y[3*YW +: YW], 15);
    @(posedge clk);
    #1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
